// File: rtl/cla_serial_adder_ctrl_pkg.sv
// Shared definitions for the byte-serial carry-lookahead add/subtract controller.
package cla_serial_adder_ctrl_pkg;

    localparam int SLICE_W = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/cla_serial_adder_ctrl_cla_block.sv
// Combinational 8-bit carry-lookahead slice: sum plus group generate/propagate.
// The slice's own carry out is left to the caller as g | (p & cin).
module cla_block
    import cla_serial_adder_ctrl_pkg::*;
(
    input  logic [SLICE_W-1:0] a,
    input  logic [SLICE_W-1:0] b,
    input  logic               cin,
    output logic [SLICE_W-1:0] s,
    output logic               g,
    output logic               p
);

    logic [SLICE_W-1:0] gen;
    logic [SLICE_W-1:0] prop;
    logic [SLICE_W:0]   carry;
    logic [SLICE_W-1:0] grp_gen;

    // Each carry is a flat sum of products over lower bit generates, so no
    // carry depends on another carry (lookahead rather than ripple).
    always_comb begin
        gen      = a & b;
        prop     = a ^ b;
        carry    = '0;
        grp_gen  = '0;
        carry[0] = cin;
        for (int i = 0; i < SLICE_W; i++) begin
            logic gterm;
            logic pchain;
            gterm  = 1'b0;
            pchain = 1'b1;
            for (int j = i; j >= 0; j--) begin
                gterm  = gterm | (gen[j] & pchain);
                pchain = pchain & prop[j];
            end
            grp_gen[i]   = gterm;
            carry[i + 1] = gterm | (pchain & cin);
        end
        s = prop ^ carry[SLICE_W-1:0];
        g = grp_gen[SLICE_W-1];
        p = &prop;
    end

endmodule

// File: rtl/cla_serial_adder_ctrl.sv
// Byte-serial add/subtract controller. One shared 8-bit CLA slice is stepped
// across the operands least-significant byte first; the inter-byte carry
// lives in carry_q.
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | waiting for a request; in_ready high unless reset
// RUN   | one byte per cycle through the slice, beat_q selects the byte
// DONE  | result/cout/overflow held, out_valid high until out_ready
module cla_serial_adder_ctrl
    import cla_serial_adder_ctrl_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             cout,
    output logic             overflow
);

    localparam int NSLICE = WIDTH / SLICE_W;
    localparam int BEAT_W = (NSLICE > 1) ? $clog2(NSLICE) : 1;
    localparam int IDX_W  = (WIDTH > 8) ? $clog2(WIDTH) : 3;
    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(NSLICE - 1);

    state_t             state_q;
    state_t             state_d;
    logic [BEAT_W-1:0]  beat_q;
    logic [WIDTH-1:0]   a_q;
    logic [WIDTH-1:0]   b_q;
    logic               carry_q;

    logic [IDX_W-1:0]   base;
    logic [SLICE_W-1:0] slice_a;
    logic [SLICE_W-1:0] slice_b;
    logic [SLICE_W-1:0] slice_s;
    logic               slice_g;
    logic               slice_p;
    logic               slice_cout;
    logic               msb_cin;
    logic               last_beat;

    assign in_ready  = (state_q == IDLE) && !reset;
    assign out_valid = (state_q == DONE);
    assign last_beat = (beat_q == LAST_BEAT);

    // Byte select feeding the shared slice, plus the carry into the top bit
    // recovered from the sum for signed overflow detection.
    always_comb begin
        base       = IDX_W'(beat_q) << $clog2(SLICE_W);
        slice_a    = a_q[base +: SLICE_W];
        slice_b    = b_q[base +: SLICE_W];
        slice_cout = slice_g | (slice_p & carry_q);
        msb_cin    = a_q[WIDTH-1] ^ b_q[WIDTH-1] ^ slice_s[SLICE_W-1];
    end

    cla_block u_cla (
        .a   (slice_a),
        .b   (slice_b),
        .cin (carry_q),
        .s   (slice_s),
        .g   (slice_g),
        .p   (slice_p)
    );

    // State register.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state decode; a result handshake in DONE returns to IDLE only, so a
    // waiting request is picked up on the following cycle.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: if (in_valid)  state_d = RUN;
            RUN:  if (last_beat) state_d = DONE;
            DONE: if (out_ready) state_d = IDLE;
            default:             state_d = IDLE;
        endcase
    end

    // Operand capture, per-beat slice write-back and final flag capture.
    // Subtract is A + ~B + 1, with the +1 entering as the first carry in.
    always_ff @(posedge clock) begin
        if (reset) begin
            beat_q   <= '0;
            a_q      <= '0;
            b_q      <= '0;
            carry_q  <= 1'b0;
            result   <= '0;
            cout     <= 1'b0;
            overflow <= 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        a_q     <= a;
                        b_q     <= sub ? ~b : b;
                        carry_q <= sub;
                        beat_q  <= '0;
                        result  <= '0;
                    end
                end
                RUN: begin
                    result[base +: SLICE_W] <= slice_s;
                    carry_q                 <= slice_cout;
                    beat_q                  <= beat_q + 1'b1;
                    if (last_beat) begin
                        cout     <= slice_cout;
                        overflow <= msb_cin ^ slice_cout;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cla_serial_adder_ctrl.sv
// Randomized scoreboard bench for the byte-serial add/subtract controller.
module tb_cla_serial_adder_ctrl;

    localparam int WIDTH  = 32;
    localparam int NSLICE = WIDTH / 8;

    typedef struct {
        logic [WIDTH-1:0] r;
        logic             c;
        logic             v;
    } exp_t;

    logic             clock;
    logic             reset;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             sub;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] result;
    logic             cout;
    logic             overflow;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_pass   = 0;
    bit   rnd_on   = 0;

    cla_serial_adder_ctrl #(.WIDTH(WIDTH)) dut (
        .clock     (clock),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .sub       (sub),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .cout      (cout),
        .overflow  (overflow)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Reference: plain integer arithmetic on the operand values.
    function automatic exp_t model(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y,
                                   input logic s);
        exp_t e;
        longint ux, uy, sx, sy, ss;
        ux = longint'({32'd0, x});
        uy = longint'({32'd0, y});
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        if (s) begin
            e.r = x - y;
            e.c = (ux >= uy);
            ss  = sx - sy;
        end else begin
            e.r = x + y;
            e.c = ((ux + uy) >= 64'sh1_0000_0000);
            ss  = sx + sy;
        end
        e.v = (ss > 64'sh7FFF_FFFF) || (ss < -64'sh8000_0000);
        return e;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_checks++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got %0h, required %0h", name, act, req);
    endtask

    // Monitor: every completed response is popped and compared.
    always @(negedge clock) begin
        if (!reset && out_valid === 1'b1 && out_ready === 1'b1) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                $display("FAIL unexpected_response: got result %0h with no request pending", result);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("result",   64'(result),   64'(e.r));
                check("cout",     64'(cout),     64'(e.c));
                check("overflow", 64'(overflow), 64'(e.v));
            end
        end
    end

    // Called at posedge+1; returns at posedge+1 just after the accept edge.
    task automatic send(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y,
                        input logic s, input bit push);
        bit acc;
        acc      = 0;
        in_valid = 1'b1;
        a        = x;
        b        = y;
        sub      = s;
        for (int k = 0; k < 500 && !acc; k++) begin
            @(negedge clock);
            if (in_ready === 1'b1) begin
                acc = 1;
                if (push) exp_q.push_back(model(x, y, s));
            end
            @(posedge clock);
            #1;
        end
        in_valid = 1'b0;
        a        = $urandom;
        b        = $urandom;
        sub      = 1'($urandom_range(0, 1));
        if (!acc) begin
            n_checks++;
            $display("FAIL accept_timeout: got no accept, required accept for a=%0h b=%0h", x, y);
        end
    endtask

    task automatic wait_valid(output int lat);
        lat = 0;
        while (out_valid !== 1'b1 && lat < 50) begin
            @(posedge clock);
            #1;
            lat++;
        end
    endtask

    task automatic run_op(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y,
                          input logic s, input string name);
        int lat;
        send(x, y, s, 1);
        wait_valid(lat);
        check({name, "_latency"}, 64'(lat), 64'(NSLICE));
        @(posedge clock);
        #1;
    endtask

    function automatic logic [WIDTH-1:0] pick();
        logic [WIDTH-1:0] edges [4];
        edges[0] = 32'h0000_0000;
        edges[1] = 32'hFFFF_FFFF;
        edges[2] = 32'h8000_0000;
        edges[3] = 32'h7FFF_FFFF;
        if ($urandom_range(0, 3) == 0) return edges[$urandom_range(0, 3)];
        return $urandom;
    endfunction

    initial begin
        int lat;
        reset     = 1'b1;
        in_valid  = 1'b0;
        a         = '0;
        b         = '0;
        sub       = 1'b0;
        out_ready = 1'b1;

        repeat (2) @(posedge clock);
        @(negedge clock);
        check("rst_in_ready",  64'(in_ready),  64'd0);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_result",    64'(result),    64'd0);
        check("rst_cout",      64'(cout),      64'd0);
        check("rst_overflow",  64'(overflow),  64'd0);
        @(posedge clock);
        #1;
        reset = 1'b0;
        @(negedge clock);
        check("post_rst_in_ready", 64'(in_ready), 64'd1);
        @(posedge clock);
        #1;

        run_op(32'h0000_00FF, 32'h0000_0001, 1'b0, "small_add");
        run_op(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, "ripple");
        run_op(32'h8000_0000, 32'h0000_0001, 1'b1, "sub_ovf");
        run_op(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, "add_ovf");

        // Backpressure with a request waiting.
        out_ready = 1'b0;
        send(32'd5, 32'd7, 1'b0, 1);
        wait_valid(lat);
        check("bp_latency", 64'(lat), 64'(NSLICE));
        in_valid = 1'b1;
        a        = 32'h0000_0100;
        b        = 32'h0000_0020;
        sub      = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clock);
            check("bp_out_valid", 64'(out_valid), 64'd1);
            check("bp_result",    64'(result),    64'd12);
            check("bp_in_ready",  64'(in_ready),  64'd0);
            @(posedge clock);
            #1;
        end
        out_ready = 1'b1;
        @(negedge clock);
        check("bp_handshake_in_ready", 64'(in_ready), 64'd0);
        @(posedge clock);
        #1;
        send(32'h0000_0100, 32'h0000_0020, 1'b0, 1);
        wait_valid(lat);
        check("bp_next_latency", 64'(lat), 64'(NSLICE));
        @(posedge clock);
        #1;

        // Reset while beat 2 is being computed.
        send(32'h1234_5678, 32'h1111_1111, 1'b0, 0);
        repeat (2) begin
            @(posedge clock);
            #1;
        end
        reset = 1'b1;
        @(negedge clock);
        check("midrst_in_ready_comb", 64'(in_ready), 64'd0);
        @(posedge clock);
        #1;
        check("midrst_out_valid", 64'(out_valid), 64'd0);
        check("midrst_result",    64'(result),    64'd0);
        check("midrst_cout",      64'(cout),      64'd0);
        reset = 1'b0;
        @(negedge clock);
        check("midrst_idle", 64'(in_ready), 64'd1);
        @(posedge clock);
        #1;
        run_op(32'h0000_0002, 32'h0000_0003, 1'b1, "after_rst_sub");

        // Randomized traffic with random consumer stalls.
        rnd_on = 1;
        fork
            begin
                while (rnd_on) begin
                    @(posedge clock);
                    #1;
                    out_ready = 1'($urandom_range(0, 1));
                end
            end
        join_none
        for (int n = 0; n < 60; n++) begin
            logic [WIDTH-1:0] x, y;
            x = pick();
            y = pick();
            send(x, y, 1'($urandom_range(0, 1)), 1);
            repeat ($urandom_range(0, 3)) begin
                @(posedge clock);
                #1;
            end
        end
        for (int k = 0; k < 2000 && exp_q.size() != 0; k++) begin
            @(posedge clock);
            #1;
        end
        rnd_on = 0;
        repeat (2) @(posedge clock);
        #1;
        out_ready = 1'b1;
        repeat (2) @(posedge clock);
        check("drain_pending", 64'(exp_q.size()), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
